// File: rtl/button_conditioner_pkg.sv
// Shared constants and channel-state classification for the button conditioner.
package button_conditioner_pkg;

    localparam int SYNC_DEPTH           = 2;
    localparam int DEFAULT_NR_OF_INPUTS = 2;
    localparam int DEFAULT_NR_OF_BITS   = 8;
    localparam int DEFAULT_STABLE_TICKS = 4;

    typedef enum logic [1:0] {
        CH_IDLE     = 2'b00,
        CH_COUNTING = 2'b01,
        CH_FLIP     = 2'b10
    } chan_state_e;

    // A mismatch whose counter already sits on the last step flips on the next tick.
    function automatic chan_state_e classify(input logic mismatch, input logic at_last);
        chan_state_e st;
        if (!mismatch) begin
            st = CH_IDLE;
        end else if (at_last) begin
            st = CH_FLIP;
        end else begin
            st = CH_COUNTING;
        end
        return st;
    endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: 2-flop synchronizer, tick-based debounce counter,
// registered level and one-cycle press/release pulses.
module button_debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int NrOfBits    = DEFAULT_NR_OF_BITS,
    parameter int StableTicks = DEFAULT_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [NrOfBits-1:0] CNT_ZERO = {NrOfBits{1'b0}};
    localparam logic [NrOfBits-1:0] CNT_ONE  = NrOfBits'(1);
    localparam logic [NrOfBits-1:0] CNT_LAST = NrOfBits'(StableTicks - 1);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic [NrOfBits-1:0]   cnt_q, cnt_d;
    logic                  lvl_q, lvl_d;
    logic                  press_q, press_d;
    logic                  rel_q, rel_d;
    logic                  sync_out_s;
    chan_state_e           state_s;

    // Next-state: synchronizer shift, debounce count/flip, edge pulses.
    always_comb begin
        sync_d     = {sync_q[SYNC_DEPTH-2:0], pin};
        sync_out_s = sync_q[SYNC_DEPTH-1];
        state_s    = classify(sync_out_s != lvl_q, cnt_q == CNT_LAST);
        cnt_d      = cnt_q;
        lvl_d      = lvl_q;
        case (state_s)
            CH_IDLE: begin
                cnt_d = CNT_ZERO;
            end
            CH_COUNTING: begin
                if (tick) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            CH_FLIP: begin
                if (tick) begin
                    lvl_d = sync_out_s;
                    cnt_d = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d = CNT_ZERO;
                lvl_d = lvl_q;
            end
        endcase
        press_d = lvl_d & ~lvl_q;
        rel_d   = ~lvl_d & lvl_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {SYNC_DEPTH{1'b0}};
            cnt_q   <= CNT_ZERO;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level         = lvl_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw button pins into debounced levels and press/release pulses.
// Optional BUTTON_CONDITIONER_ACTIVE_LOW_EN: pins are pressed when low.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NrOfInputs  = DEFAULT_NR_OF_INPUTS,
    parameter int NrOfBits    = DEFAULT_NR_OF_BITS,
    parameter int StableTicks = DEFAULT_STABLE_TICKS
) (
    input  logic                  GlobalClock,
    input  logic                  RST,
    input  logic                  ClockTick,
    input  logic [NrOfInputs-1:0] ButtonsIn,
    output logic [NrOfInputs-1:0] ButtonsLevel,
    output logic [NrOfInputs-1:0] ButtonsPress,
    output logic [NrOfInputs-1:0] ButtonsRelease
);

    logic [NrOfInputs-1:0] pin_s;

`ifdef BUTTON_CONDITIONER_ACTIVE_LOW_EN
    assign pin_s = ~ButtonsIn;
`else
    assign pin_s = ButtonsIn;
`endif

    for (genvar i = 0; i < NrOfInputs; i++) begin : g_ch
        button_debounce_channel #(
            .NrOfBits    (NrOfBits),
            .StableTicks (StableTicks)
        ) u_ch (
            .clk           (GlobalClock),
            .rst           (RST),
            .tick          (ClockTick),
            .pin           (pin_s[i]),
            .level         (ButtonsLevel[i]),
            .press_pulse   (ButtonsPress[i]),
            .release_pulse (ButtonsRelease[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: a run-length debounce model predicts every output cycle.
module tb_button_conditioner;

    localparam int N      = 2;
    localparam int STABLE = 4;
`ifdef BUTTON_CONDITIONER_ACTIVE_LOW_EN
    localparam logic [N-1:0] POL = 2'b11;
`else
    localparam logic [N-1:0] POL = 2'b00;
`endif

    logic         clk = 1'b0;
    logic         RST = 1'b1;
    logic         ClockTick = 1'b0;
    logic [N-1:0] ButtonsIn = POL;
    logic [N-1:0] ButtonsLevel, ButtonsPress, ButtonsRelease;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] pr;
        logic [N-1:0] rl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   press_obs[N];
    int   rel_obs[N];
    logic [N-1:0] held = 2'b00;
    bit   rand_ticks = 1'b0;
    int   tick_div = 0;

    button_conditioner #(.NrOfInputs(N), .NrOfBits(8), .StableTicks(STABLE)) dut (
        .GlobalClock    (clk),
        .RST            (RST),
        .ClockTick      (ClockTick),
        .ButtonsIn      (ButtonsIn),
        .ButtonsLevel   (ButtonsLevel),
        .ButtonsPress   (ButtonsPress),
        .ButtonsRelease (ButtonsRelease)
    );

    always #5 clk = ~clk;

    // Tick source: every 10 cycles in directed phases, random in the soak phase.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ticks) begin
                ClockTick = ($urandom_range(0, 3) == 0);
            end else begin
                ClockTick = (tick_div == 9);
                tick_div  = (tick_div == 9) ? 0 : tick_div + 1;
            end
        end
    end

    // Reference model: pin seen two edges late; level follows after STABLE
    // consecutive mismatching ticks; any agreement restarts the run.
    logic [1:0] seen_hist[N];
    logic       m_lvl[N];
    int         m_run[N];

    initial begin
        for (int c = 0; c < N; c++) begin
            seen_hist[c] = 2'b00; m_lvl[c] = 1'b0; m_run[c] = 0;
            press_obs[c] = 0; rel_obs[c] = 0;
        end
        forever begin
            exp_t e;
            @(posedge clk);
            e = '0;
            for (int c = 0; c < N; c++) begin
                logic pin_now, seen, old;
                pin_now = ButtonsIn[c] ^ POL[c];
                if (RST) begin
                    seen_hist[c] = 2'b00; m_lvl[c] = 1'b0; m_run[c] = 0;
                end else begin
                    seen = seen_hist[c][1];
                    old  = m_lvl[c];
                    if (seen == old) begin
                        m_run[c] = 0;
                    end else if (ClockTick) begin
                        m_run[c] = m_run[c] + 1;
                        if (m_run[c] >= STABLE) begin
                            m_lvl[c] = seen;
                            m_run[c] = 0;
                        end
                    end
                    e.pr[c]  = m_lvl[c] & ~old;
                    e.rl[c]  = ~m_lvl[c] & old;
                    seen_hist[c] = {seen_hist[c][0], pin_now};
                end
                e.lvl[c] = m_lvl[c];
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compare each registered output cycle against the scoreboard.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks += 3;
                if (ButtonsLevel !== e.lvl) begin
                    n_fail++;
                    $display("FAIL level t=%0t got=%b exp=%b", $time, ButtonsLevel, e.lvl);
                end
                if (ButtonsPress !== e.pr) begin
                    n_fail++;
                    $display("FAIL press t=%0t got=%b exp=%b", $time, ButtonsPress, e.pr);
                end
                if (ButtonsRelease !== e.rl) begin
                    n_fail++;
                    $display("FAIL release t=%0t got=%b exp=%b", $time, ButtonsRelease, e.rl);
                end
                for (int c = 0; c < N; c++) begin
                    if (ButtonsPress[c] === 1'b1) press_obs[c]++;
                    if (ButtonsRelease[c] === 1'b1) rel_obs[c]++;
                end
            end
        end
    end

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ButtonsIn = held ^ POL;
        end
    endtask

    initial begin
        int p0[N];
        int r0[N];
        int nt;
        int guard;

        // Reset held for 3 cycles with both buttons pressed.
        held = 2'b11;
        RST  = 1'b1;
        run_cycles(3);
        check_int("reset_level", int'(ButtonsLevel), 0);
        check_int("reset_press", int'(ButtonsPress), 0);
        RST = 1'b0;
        for (int c = 0; c < N; c++) begin p0[c] = press_obs[c]; r0[c] = rel_obs[c]; end
        run_cycles(60);
        check_int("post_reset_level", int'(ButtonsLevel), 3);
        check_int("post_reset_press0", press_obs[0] - p0[0], 1);
        check_int("post_reset_press1", press_obs[1] - p0[1], 1);

        // Release both.
        held = 2'b00;
        for (int c = 0; c < N; c++) begin p0[c] = press_obs[c]; r0[c] = rel_obs[c]; end
        run_cycles(60);
        check_int("release_rel0", rel_obs[0] - r0[0], 1);
        check_int("release_rel1", rel_obs[1] - r0[1], 1);
        check_int("release_press0", press_obs[0] - p0[0], 0);

        // Bounce on channel 0, then held pressed.
        for (int c = 0; c < N; c++) begin p0[c] = press_obs[c]; r0[c] = rel_obs[c]; end
        for (int k = 0; k < 60; k++) begin
            held[0] = ((k / 7) % 2 == 0);
            run_cycles(1);
        end
        check_int("bounce_no_press", press_obs[0] - p0[0], 0);
        held[0] = 1'b1;
        run_cycles(60);
        check_int("bounce_one_press", press_obs[0] - p0[0], 1);
        check_int("bounce_no_release", rel_obs[0] - r0[0], 0);
        check_int("bounce_ch1_quiet", press_obs[1] - p0[1], 0);

        // Clean release of channel 0.
        held[0] = 1'b0;
        for (int c = 0; c < N; c++) begin p0[c] = press_obs[c]; r0[c] = rel_obs[c]; end
        run_cycles(60);
        check_int("clean_release", rel_obs[0] - r0[0], 1);
        check_int("clean_release_no_press", press_obs[0] - p0[0], 0);

        // Reset after 3 mismatching ticks on channel 1 discards the count.
        held[1] = 1'b1;
        for (int c = 0; c < N; c++) begin p0[c] = press_obs[c]; r0[c] = rel_obs[c]; end
        run_cycles(1);
        @(posedge clk);
        @(posedge clk);
        nt = 0;
        guard = 0;
        while (nt < 3 && guard < 100) begin
            if (ClockTick) nt++;
            guard++;
            if (nt < 3) @(posedge clk);
        end
        check_int("midcount_ticks_seen", nt, 3);
        @(negedge clk);
        RST = 1'b1;
        ButtonsIn = held ^ POL;
        @(negedge clk);
        RST = 1'b0;
        check_int("midcount_no_press_before_reset", press_obs[1] - p0[1], 0);
        run_cycles(30);
        check_int("midcount_needs_4_more", press_obs[1] - p0[1], 0);
        run_cycles(30);
        check_int("midcount_press_after", press_obs[1] - p0[1], 1);

        // Random soak: bouncy pins, random ticks, occasional reset.
        rand_ticks = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 19) == 0) held[c] = ~held[c];
            end
            RST = ($urandom_range(0, 499) == 0);
            run_cycles(1);
        end
        RST = 1'b0;
        run_cycles(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
